// File: rtl/jtopl_eg_pkg.sv
// Shared types and constants for the OPL envelope generator.
package jtopl_eg_pkg;

   typedef enum logic [2:0] {
      ATTACK  = 3'd0,
      DECAY   = 3'd1,
      SUSTAIN = 3'd2,
      RELEASE = 3'd3,
      DAMP    = 3'd4
   } egState_t;

   // Sub-step patterns for rates below 48, indexed by rate[1:0]
   localparam logic [3:0][7:0] STEP_PAT = {8'b11111110, 8'b11101110,
                                           8'b11101010, 8'b10101010};

   // Base rate used while damping a voice before a new attack
   localparam logic [3:0] DAMP_RATE = 4'd12;

   // Effective rate from a 4-bit base rate and key scaling, clamped to 63.
   // A zero base rate always means the envelope is frozen.
   function automatic logic [5:0] calcRate(input logic [3:0] baseRate,
                                           input logic [3:0] keycode,
                                           input logic       ks);
      logic [6:0] sum;
      sum = {1'b0, baseRate, 2'b00} + (ks ? {3'b000, keycode} : {5'b00000, keycode[3:2]});
      if (baseRate == 4'd0)
         return 6'd0;
      else if (sum > 7'd63)
         return 6'd63;
      else
         return sum[5:0];
   endfunction

endpackage

// File: rtl/jtopl_eg_step.sv
// Decides whether the envelope moves on this visit and by how much,
// from the effective rate and the global envelope counter.
module jtopl_eg_step
   import jtopl_eg_pkg::*;
(
   input  logic [5:0]  i_rate,
   input  logic [14:0] i_cnt,
   output logic        o_step,
   output logic [3:0]  o_inc
);

   logic [3:0]  w_shift;
   logic [14:0] w_mask;
   logic [2:0]  w_patIdx;

   // Slow rates step on a counter-derived pattern; fast rates step every visit
   always_comb begin
      w_shift  = 4'd12 - i_rate[5:2];
      w_mask   = (15'd1 << w_shift) - 15'd1;
      w_patIdx = 3'(i_cnt >> w_shift);
      o_step   = 1'b0;
      o_inc    = 4'd1;
      if (i_rate == 6'd0) begin
         o_step = 1'b0;
      end else if (i_rate >= 6'd48) begin
         o_step = 1'b1;
         case (i_rate[3:2])
            2'd0:    o_inc = 4'd1;
            2'd1:    o_inc = 4'd2;
            2'd2:    o_inc = 4'd4;
            default: o_inc = 4'd8;
         endcase
      end else begin
         o_step = ((i_cnt & w_mask) == 15'd0) && STEP_PAT[i_rate[1:0]][w_patIdx];
      end
   end

endmodule

// File: rtl/jtopl_eg_mc.sv
// Time-multiplexed OPL envelope generator: one operator slot per cen,
// per-slot state kept in a circular store that rotates once per cen.
module jtopl_eg_mc
   import jtopl_eg_pkg::*;
#(
   parameter int CH      = 9,
   parameter int OPS     = 2,
   parameter int EGW     = 10,
   parameter int DAMP_EN = 1
)(
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_cen,
   input  logic           i_zero,
   input  logic           i_eg_stop,
   input  logic           i_keyon,
   input  logic           i_en_sus,
   input  logic [3:0]     i_arate,
   input  logic [3:0]     i_drate,
   input  logic [3:0]     i_rrate,
   input  logic [3:0]     i_sl,
   input  logic [3:0]     i_keycode,
   input  logic           i_ks,
   input  logic [6:0]     i_tl,
   input  logic           i_amsen,
   input  logic           i_ams,
   input  logic [6:0]     i_lfo_mod,
   output logic [EGW-1:0] o_eg_out,
   output logic           o_pg_rst,
   output logic           o_slot0_out
);

   localparam int             SLOTS  = CH * OPS;
   localparam logic [EGW-1:0] MAXATT = '1;

   logic [EGW-1:0] r_attn [SLOTS];
   egState_t       r_state [SLOTS];
   logic [SLOTS-1:0] r_key;
   logic [14:0]    r_cnt;

   logic [EGW-1:0] r_attn1;
   logic [6:0]     r_tl1;
   logic [6:0]     r_am1;
   logic           r_pg1;
   logic           r_zero1;

   logic [EGW-1:0] w_attn;
   egState_t       w_state;
   logic           w_last;
   logic [3:0]     w_rSel;
   logic [5:0]     w_rate;
   logic           w_stepRaw;
   logic           w_step;
   logic [3:0]     w_inc;
   logic [EGW-1:0] w_atkDec;
   logic [EGW-1:0] w_atkNext;
   logic [EGW:0]   w_incSum;
   logic [EGW-1:0] w_incNext;
   logic           w_atkFast;
   logic           w_keyOnEdge;
   logic           w_keyOffEdge;
   logic [EGW-1:0] w_nextAttn;
   egState_t       w_nextState;
   logic           w_pg;
   logic [6:0]     w_am;
   logic [EGW+1:0] w_sum;
   logic [EGW-1:0] w_egNext;

   assign w_attn       = r_attn[0];
   assign w_state      = r_state[0];
   assign w_last       = r_key[0];
   assign w_keyOnEdge  = i_keyon & ~w_last;
   assign w_keyOffEdge = ~i_keyon & w_last;

   // Base rate follows the state the slot is in at the start of the visit
   always_comb begin
      case (w_state)
         ATTACK:  w_rSel = i_arate;
         DECAY:   w_rSel = i_drate;
         DAMP:    w_rSel = DAMP_RATE;
         default: w_rSel = i_rrate;
      endcase
   end

   assign w_rate    = calcRate(w_rSel, i_keycode, i_ks);
   assign w_atkFast = calcRate(i_arate, i_keycode, i_ks) >= 6'd60;

   jtopl_eg_step u_step (
      .i_rate (w_rate),
      .i_cnt  (r_cnt),
      .o_step (w_stepRaw),
      .o_inc  (w_inc)
   );

   assign w_step    = w_stepRaw & ~i_eg_stop;
   assign w_atkDec  = (w_attn >> 3) + {{(EGW-4){1'b0}}, w_inc};
   assign w_atkNext = (w_attn > w_atkDec) ? (w_attn - w_atkDec) : '0;
   assign w_incSum  = {1'b0, w_attn} + {{(EGW-3){1'b0}}, w_inc};
   assign w_incNext = w_incSum[EGW] ? MAXATT : w_incSum[EGW-1:0];

   // Key edges take priority over stepping; otherwise advance within the state
   always_comb begin
      w_nextAttn  = w_attn;
      w_nextState = w_state;
      w_pg        = 1'b0;
      if (w_keyOffEdge) begin
         w_nextState = RELEASE;
      end else if (w_keyOnEdge) begin
         if (DAMP_EN != 0 && w_attn != MAXATT) begin
            w_nextState = DAMP;
         end else begin
            w_nextState = ATTACK;
            w_pg        = 1'b1;
            if (w_atkFast)
               w_nextAttn = '0;
         end
      end else begin
         case (w_state)
            ATTACK: begin
               if (w_step)
                  w_nextAttn = (w_rate >= 6'd60) ? '0 : w_atkNext;
               if (w_nextAttn == '0)
                  w_nextState = DECAY;
            end
            DECAY: begin
               if (w_step)
                  w_nextAttn = w_incNext;
               if ((i_sl == 4'hF) ? (w_nextAttn == MAXATT)
                                  : (w_nextAttn[EGW-1:EGW-4] >= i_sl))
                  w_nextState = SUSTAIN;
            end
            SUSTAIN: begin
               if (!i_en_sus && w_step)
                  w_nextAttn = w_incNext;
            end
            DAMP: begin
               if (w_step)
                  w_nextAttn = w_incNext;
               if (w_nextAttn == MAXATT) begin
                  w_nextState = ATTACK;
                  w_pg        = 1'b1;
               end
            end
            default: begin
               if (w_step)
                  w_nextAttn = w_incNext;
            end
         endcase
      end
   end

   assign w_am     = i_amsen ? (i_ams ? i_lfo_mod : {2'b00, i_lfo_mod[6:2]}) : 7'd0;
   assign w_sum    = {2'b00, r_attn1} + {2'b00, r_tl1, {(EGW-7){1'b0}}}
                   + {{(EGW-5){1'b0}}, r_am1};
   assign w_egNext = (w_sum > {2'b00, MAXATT}) ? MAXATT : w_sum[EGW-1:0];

   // Rotate slot storage, run the global counter and the two output stages
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < SLOTS; k++) begin
            r_attn[k]  <= MAXATT;
            r_state[k] <= RELEASE;
         end
         r_key       <= '0;
         r_cnt       <= '0;
         r_attn1     <= MAXATT;
         r_tl1       <= '0;
         r_am1       <= '0;
         r_pg1       <= 1'b0;
         r_zero1     <= 1'b0;
         o_eg_out    <= MAXATT;
         o_pg_rst    <= 1'b0;
         o_slot0_out <= 1'b0;
      end else if (i_cen) begin
         for (int k = 0; k < SLOTS-1; k++) begin
            r_attn[k]  <= r_attn[k+1];
            r_state[k] <= r_state[k+1];
         end
         r_attn[SLOTS-1]  <= w_nextAttn;
         r_state[SLOTS-1] <= w_nextState;
         r_key            <= {i_keyon, r_key[SLOTS-1:1]};
         if (i_zero && !i_eg_stop)
            r_cnt <= r_cnt + 15'd1;
         r_attn1     <= w_nextAttn;
         r_tl1       <= i_tl;
         r_am1       <= w_am;
         r_pg1       <= w_pg;
         r_zero1     <= i_zero;
         o_eg_out    <= w_egNext;
         o_pg_rst    <= r_pg1;
         o_slot0_out <= r_zero1;
      end
   end

endmodule

// File: tb/tb_jtopl_eg_mc.sv
// Directed bench for the envelope generator: default 18-slot build plus a
// 72-slot, 12-bit build for recirculation and width checks.
module tb_jtopl_eg_mc;

   logic        clk = 1'b0;
   logic        rst, cen, zero, egStop, keyon, enSus, ks, amsen, ams;
   logic [3:0]  arate, drate, rrate, sl, keycode;
   logic [6:0]  tl, lfoMod;
   logic [9:0]  egOut;
   logic        pgRst, slot0Out;
   logic        cen2, zero2, keyon2;
   logic [11:0] egOut2;
   logic        pgRst2, slot0Out2;

   int errors = 0;
   int checks = 0;
   int prevSlot = -1;
   int prevSlot2 = -1;
   int cntModel = 0;
   logic key3;
   logic [9:0]  obsEg [18];
   logic        obsPg [18];
   logic        obsZ [18];
   logic [11:0] obsEg2 [72];
   logic        obsPg2 [72];
   logic        obsZ2 [72];

   jtopl_eg_mc dut (
      .i_clk(clk), .i_rst(rst), .i_cen(cen), .i_zero(zero), .i_eg_stop(egStop),
      .i_keyon(keyon), .i_en_sus(enSus), .i_arate(arate), .i_drate(drate),
      .i_rrate(rrate), .i_sl(sl), .i_keycode(keycode), .i_ks(ks), .i_tl(tl),
      .i_amsen(amsen), .i_ams(ams), .i_lfo_mod(lfoMod),
      .o_eg_out(egOut), .o_pg_rst(pgRst), .o_slot0_out(slot0Out)
   );

   jtopl_eg_mc #(.CH(18), .OPS(4), .EGW(12), .DAMP_EN(1)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_cen(cen2), .i_zero(zero2), .i_eg_stop(egStop),
      .i_keyon(keyon2), .i_en_sus(enSus), .i_arate(arate), .i_drate(drate),
      .i_rrate(rrate), .i_sl(sl), .i_keycode(keycode), .i_ks(ks), .i_tl(tl),
      .i_amsen(amsen), .i_ams(ams), .i_lfo_mod(lfoMod),
      .o_eg_out(egOut2), .o_pg_rst(pgRst2), .o_slot0_out(slot0Out2)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Independent reference for the slow-rate step decision
   function automatic bit expStep(input int rate, input int cnt);
      logic [7:0] pat;
      int shift;
      if (rate == 0) return 1'b0;
      if (rate >= 48) return 1'b1;
      shift = 12 - rate / 4;
      if ((cnt % (1 << shift)) != 0) return 1'b0;
      case (rate % 4)
         0: pat = 8'hAA;
         1: pat = 8'hEA;
         2: pat = 8'hEE;
         default: pat = 8'hFE;
      endcase
      return pat[(cnt >> shift) % 8];
   endfunction

   // One cen on the small build; captures the output of the previous visit
   task automatic visit(input int s);
      zero  = (s == 0);
      keyon = (s == 3) ? key3 : 1'b0;
      cen   = 1'b1;
      @(posedge clk); #1;
      cen  = 1'b0;
      zero = 1'b0;
      if (s == 0 && !egStop) cntModel = (cntModel + 1) % 32768;
      if (prevSlot >= 0) begin
         obsEg[prevSlot] = egOut; obsPg[prevSlot] = pgRst; obsZ[prevSlot] = slot0Out;
      end
      prevSlot = s;
   endtask

   task automatic applyStimulus();
      for (int s = 0; s < 18; s++) visit(s);
   endtask

   task automatic visit2(input int s, input logic k);
      zero2  = (s == 0);
      keyon2 = k;
      cen2   = 1'b1;
      @(posedge clk); #1;
      cen2  = 1'b0;
      zero2 = 1'b0;
      if (prevSlot2 >= 0) begin
         obsEg2[prevSlot2] = egOut2; obsPg2[prevSlot2] = pgRst2; obsZ2[prevSlot2] = slot0Out2;
      end
      prevSlot2 = s;
   endtask

   task automatic test_reset();
      checks++; if (egOut !== 10'h3FF) begin errors++; $display("[TB] FAIL reset_eg got=%h want=3ff", egOut); end
      checks++; if (pgRst !== 1'b0) begin errors++; $display("[TB] FAIL reset_pg got=%b want=0", pgRst); end
      checks++; if (slot0Out !== 1'b0) begin errors++; $display("[TB] FAIL reset_slot0 got=%b want=0", slot0Out); end
      applyStimulus();
      checks++; if (obsEg[0] !== 10'h3FF) begin errors++; $display("[TB] FAIL idle_eg0 got=%h want=3ff", obsEg[0]); end
      checks++; if (obsZ[0] !== 1'b1) begin errors++; $display("[TB] FAIL idle_z0 got=%b want=1", obsZ[0]); end
      checks++; if (obsEg[3] !== 10'h3FF || obsPg[3] !== 1'b0 || obsZ[3] !== 1'b0) begin
         errors++; $display("[TB] FAIL idle_slot3 got=%h/%b/%b want=3ff/0/0", obsEg[3], obsPg[3], obsZ[3]); end
   endtask

   task automatic test_attack_fast();
      key3 = 1'b1;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h000 || obsPg[3] !== 1'b1) begin
         errors++; $display("[TB] FAIL keyon_fast got=%h/%b want=000/1", obsEg[3], obsPg[3]); end
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h000 || obsPg[3] !== 1'b0) begin
         errors++; $display("[TB] FAIL keyon_hold got=%h/%b want=000/0", obsEg[3], obsPg[3]); end
   endtask

   task automatic test_release();
      key3 = 1'b0; rrate = 4'd15;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h000) begin errors++; $display("[TB] FAIL keyoff_edge got=%h want=000", obsEg[3]); end
      for (int r = 1; r <= 32; r++) begin
         applyStimulus();
         if (r == 1) begin
            checks++; if (obsEg[3] !== 10'h008) begin errors++; $display("[TB] FAIL release_first got=%h want=008", obsEg[3]); end
         end
      end
      checks++; if (obsEg[3] !== 10'h100) begin errors++; $display("[TB] FAIL release_level got=%h want=100", obsEg[3]); end
      rrate = 4'd0;
   endtask

   task automatic test_damp();
      int firstPg = -1;
      logic [9:0] egAt95 = '0;
      logic [9:0] egAtPg = '0;
      key3 = 1'b1; ks = 1'b1; keycode = 4'd15;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h100 || obsPg[3] !== 1'b0) begin
         errors++; $display("[TB] FAIL damp_entry got=%h/%b want=100/0", obsEg[3], obsPg[3]); end
      for (int v = 1; v <= 120 && firstPg < 0; v++) begin
         applyStimulus();
         if (v == 95) egAt95 = obsEg[3];
         if (obsPg[3] === 1'b1) begin firstPg = v; egAtPg = obsEg[3]; end
      end
      checks++; if (egAt95 !== 10'h3F8) begin errors++; $display("[TB] FAIL damp_ramp got=%h want=3f8", egAt95); end
      checks++; if (firstPg != 96) begin errors++; $display("[TB] FAIL damp_visits got=%0d want=96", firstPg); end
      checks++; if (egAtPg !== 10'h3FF) begin errors++; $display("[TB] FAIL damp_top got=%h want=3ff", egAtPg); end
      ks = 1'b0; keycode = 4'd0; drate = 4'd13; sl = 4'd2; enSus = 1'b1;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h000 || obsPg[3] !== 1'b0) begin
         errors++; $display("[TB] FAIL damp_attack got=%h/%b want=000/0", obsEg[3], obsPg[3]); end
   endtask

   task automatic test_decay_sustain();
      for (int d = 1; d <= 69; d++) begin
         applyStimulus();
         if (d == 1) begin checks++; if (obsEg[3] !== 10'h002) begin errors++; $display("[TB] FAIL decay_first got=%h want=002", obsEg[3]); end end
         if (d == 63) begin checks++; if (obsEg[3] !== 10'h07E) begin errors++; $display("[TB] FAIL decay_pre got=%h want=07e", obsEg[3]); end end
         if (d == 64) begin checks++; if (obsEg[3] !== 10'h080) begin errors++; $display("[TB] FAIL decay_sl got=%h want=080", obsEg[3]); end end
      end
      checks++; if (obsEg[3] !== 10'h080) begin errors++; $display("[TB] FAIL sustain_hold got=%h want=080", obsEg[3]); end
      enSus = 1'b0; rrate = 4'd15;
      for (int d = 1; d <= 112; d++) begin
         applyStimulus();
         if (d == 1) begin checks++; if (obsEg[3] !== 10'h088) begin errors++; $display("[TB] FAIL perc_first got=%h want=088", obsEg[3]); end end
         if (d == 111) begin checks++; if (obsEg[3] !== 10'h3F8) begin errors++; $display("[TB] FAIL perc_pre got=%h want=3f8", obsEg[3]); end end
      end
      checks++; if (obsEg[3] !== 10'h3FF) begin errors++; $display("[TB] FAIL perc_sat got=%h want=3ff", obsEg[3]); end
   endtask

   task automatic test_eg_stop();
      key3 = 1'b0; rrate = 4'd0; enSus = 1'b1;
      applyStimulus();
      key3 = 1'b1; egStop = 1'b1;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h000 || obsPg[3] !== 1'b1) begin
         errors++; $display("[TB] FAIL stop_keyon got=%h/%b want=000/1", obsEg[3], obsPg[3]); end
      for (int r = 0; r < 3; r++) applyStimulus();
      checks++; if (obsEg[3] !== 10'h000) begin errors++; $display("[TB] FAIL stop_frozen got=%h want=000", obsEg[3]); end
      egStop = 1'b0;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h002) begin errors++; $display("[TB] FAIL stop_resume got=%h want=002", obsEg[3]); end
   endtask

   task automatic test_output_mix();
      drate = 4'd0; tl = 7'h7F;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h3FA) begin errors++; $display("[TB] FAIL tl_add got=%h want=3fa", obsEg[3]); end
      amsen = 1'b1; ams = 1'b1; lfoMod = 7'h10;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h3FF) begin errors++; $display("[TB] FAIL am_sat got=%h want=3ff", obsEg[3]); end
      ams = 1'b0; lfoMod = 7'h08;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h3FC) begin errors++; $display("[TB] FAIL am_shallow got=%h want=3fc", obsEg[3]); end
      amsen = 1'b0; tl = 7'h00;
      applyStimulus();
      checks++; if (obsEg[3] !== 10'h002) begin errors++; $display("[TB] FAIL mix_clear got=%h want=002", obsEg[3]); end
   endtask

   task automatic test_slow_rates();
      int cfgDrate [3] = '{11, 11, 10};
      int cfgKs    [3] = '{0, 1, 1};
      int cfgKc    [3] = '{0, 1, 3};
      int cfgRate  [3] = '{44, 45, 43};
      int expAttn = 2;
      for (int c = 0; c < 3; c++) begin
         drate = cfgDrate[c][3:0]; ks = cfgKs[c][0]; keycode = cfgKc[c][3:0];
         for (int r = 0; r < 16; r++) begin
            applyStimulus();
            if (expStep(cfgRate[c], cntModel)) expAttn++;
         end
         checks++; if (obsEg[3] !== expAttn[9:0]) begin
            errors++; $display("[TB] FAIL slow_rate%0d got=%h want=%h", cfgRate[c], obsEg[3], expAttn[9:0]); end
      end
      drate = 4'd0; ks = 1'b0; keycode = 4'd0;
   endtask

   task automatic test_back_to_back_wide();
      for (int s = 0; s < 72; s++) begin
         visit2(s, s == 5);
         if (s == 6) begin
            repeat (3) @(posedge clk);
            #1;
            checks++; if (egOut2 !== 12'h000 || pgRst2 !== 1'b1) begin
               errors++; $display("[TB] FAIL wide_freeze got=%h/%b want=000/1", egOut2, pgRst2); end
         end
      end
      checks++; if (obsEg2[5] !== 12'h000 || obsPg2[5] !== 1'b1) begin
         errors++; $display("[TB] FAIL wide_keyon got=%h/%b want=000/1", obsEg2[5], obsPg2[5]); end
      checks++; if (obsEg2[4] !== 12'hFFF) begin errors++; $display("[TB] FAIL wide_max got=%h want=fff", obsEg2[4]); end
      for (int s = 0; s < 72; s++) visit2(s, s == 5);
      checks++; if (obsEg2[5] !== 12'h000 || obsPg2[5] !== 1'b0) begin
         errors++; $display("[TB] FAIL wide_recirc got=%h/%b want=000/0", obsEg2[5], obsPg2[5]); end
      checks++; if (obsZ2[0] !== 1'b1 || obsZ2[1] !== 1'b0) begin
         errors++; $display("[TB] FAIL wide_slot0 got=%b%b want=10", obsZ2[0], obsZ2[1]); end
   endtask

   // Sequence all scenarios and report
   initial begin
      rst = 1'b1; cen = 1'b0; zero = 1'b0; egStop = 1'b0; keyon = 1'b0; enSus = 1'b1;
      arate = 4'd15; drate = 4'd0; rrate = 4'd0; sl = 4'd2; keycode = 4'd0; ks = 1'b0;
      tl = 7'd0; amsen = 1'b0; ams = 1'b0; lfoMod = 7'd0; key3 = 1'b0;
      cen2 = 1'b0; zero2 = 1'b0; keyon2 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_attack_fast();
      test_release();
      test_damp();
      test_decay_sustain();
      test_eg_stop();
      test_output_mix();
      test_slow_rates();
      test_back_to_back_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
